// File: rtl/lsu_axi_master_if.sv
// AXI4-Lite channel bundle between the LSU initiator (master) and the bus responder (slave).
interface lsu_axi_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI4-Lite initiator for LSU/IFU load/store requests.
// Optional build macro LSU_AXI_MISALIGN_CHECK_EN: misaligned requests are answered locally
// with an error response and never reach the bus.
module lsu_axi_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wmask,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  lsu_axi_master_if.master      axi
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdAddr = 3'd1;
  localparam logic [2:0] StRdData = 3'd2;
  localparam logic [2:0] StWrReq  = 3'd3;
  localparam logic [2:0] StWrResp = 3'd4;
  localparam logic [2:0] StResp   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  rready_q, rready_d;
  logic                  awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  bready_q, bready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

`ifdef LSU_AXI_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                      (req_size == 2'd3);
`else
  // Size only matters for the alignment check; keep it visibly consumed.
  logic unused_size;
  assign unused_size = ^req_size;
`endif

  // Next-state and next-output decode for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    awaddr_d     = awaddr_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      StIdle: begin
        // req_ready rises on the first edge after reset and stays up while idle.
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
`ifdef LSU_AXI_MISALIGN_CHECK_EN
          if (misaligned) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else
`endif
          if (req_wen) begin
            state_d   = StWrReq;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            wstrb_d   = req_wmask;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = StRdAddr;
            arvalid_d = 1'b1;
            araddr_d  = req_addr;
          end
        end
      end
      StRdAddr: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (axi.rvalid && rready_q) begin
          resp_rdata_d = axi.rdata;
          resp_err_d   = (axi.rresp != 2'b00);
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
      end
      StWrReq: begin
        // AW and W retire independently; either order or both on one edge.
        if (awvalid_q && axi.awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && axi.wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end
      end
      StWrResp: begin
        if (axi.bvalid && bready_q) begin
          resp_err_d   = (axi.bresp != 2'b00);
          resp_rdata_d = '0;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = StIdle;
      end
      default: begin
        // Corrupted encoding: drop every handshake and restart from idle.
        state_d      = StIdle;
        req_ready_d  = 1'b0;
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        bready_d     = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: configurable AXI-Lite responder, response scoreboard, timing checks.
module tb_lsu_axi_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wmask;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  always #5 clk = ~clk;

  lsu_axi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) axi ();

  lsu_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entries are {err, rdata}.
  logic [DW:0] exp_q[$];

  // Responder settings: wait cycles per channel and returned data/status.
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [DW-1:0] rdata_k = '0;
  logic [1:0]  rresp_k = 2'b00;
  logic [1:0]  bresp_k = 2'b00;

  // Responder: samples handshakes at the edge, updates its drives 1 time unit later.
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, b_pend, aw_got, w_got;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    forever begin
      @(posedge clk);
      ar_hs = axi.arvalid && axi.arready;
      r_hs  = axi.rvalid && axi.rready;
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      b_hs  = axi.bvalid && axi.bready;
      #1;
      if (rst) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.awready = 1'b0;
        axi.wready = 1'b0; axi.bvalid = 1'b0;
      end else begin
        if (ar_hs) begin
          axi.arready = 1'b0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
        end else if (axi.arvalid && !axi.arready) begin
          if (ar_cnt >= ar_wait) axi.arready = 1'b1;
          else ar_cnt++;
        end
        if (r_hs) begin
          axi.rvalid = 1'b0; r_pend = 0;
        end else if (r_pend && !axi.rvalid) begin
          if (r_cnt >= r_wait) begin
            axi.rvalid = 1'b1; axi.rdata = rdata_k; axi.rresp = rresp_k;
          end else r_cnt++;
        end
        if (aw_hs) begin
          axi.awready = 1'b0; aw_cnt = 0; aw_got = 1;
        end else if (axi.awvalid && !axi.awready) begin
          if (aw_cnt >= aw_wait) axi.awready = 1'b1;
          else aw_cnt++;
        end
        if (w_hs) begin
          axi.wready = 1'b0; w_cnt = 0; w_got = 1;
        end else if (axi.wvalid && !axi.wready) begin
          if (w_cnt >= w_wait) axi.wready = 1'b1;
          else w_cnt++;
        end
        if (aw_got && w_got) begin
          b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
        end
        if (b_hs) begin
          axi.bvalid = 1'b0; b_pend = 0;
        end else if (b_pend && !axi.bvalid) begin
          if (b_cnt >= b_wait) begin
            axi.bvalid = 1'b1; axi.bresp = bresp_k;
          end else b_cnt++;
        end
      end
    end
  end

  // Scoreboard monitor: every response pulse must be expected, match, and last one cycle.
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst) begin
      if (resp_valid) begin
        check_eq("resp_pulse_width", 64'(prev_rv), 64'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("resp_rdata", 64'(resp_rdata), 64'(e[DW-1:0]));
          check_eq("resp_err", 64'(resp_err), 64'(e[DW]));
        end
      end
      prev_rv = resp_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  // Present one request at a negedge; returns #1 after the accepting edge (E0).
  task automatic do_req(input logic wen, input logic [1:0] size, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [SW-1:0] wm,
                        input bit expect_resp, input logic [DW:0] exp);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_eq("req_ready_timeout", 64'd0, 64'd1);
    end else begin
      req_wen = wen; req_size = size; req_addr = addr; req_wdata = wd; req_wmask = wm;
      req_valid = 1'b1;
      if (expect_resp) exp_q.push_back(exp);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for all expected responses, then one more cycle back to idle.
  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd2;
    req_addr = '0; req_wdata = '0; req_wmask = '0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_arvalid", 64'(axi.arvalid), 64'd0);
    check_eq("rst_awvalid", 64'(axi.awvalid), 64'd0);
    check_eq("rst_bready", 64'(axi.bready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    check_eq("ready_after_rst", 64'(req_ready), 64'd1);

    // Zero-wait read
    rdata_k = 32'hDEAD_BEEF; rresp_k = 2'b00;
    do_req(1'b0, 2'd2, 32'h8000_0004, '0, '0, 1'b1, {1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    check_eq("rd_c1_arvalid", 64'(axi.arvalid), 64'd1);
    check_eq("rd_c1_araddr", 64'(axi.araddr), 64'h8000_0004);
    check_eq("rd_c1_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    check_eq("rd_c2_rready", 64'(axi.rready), 64'd1);
    check_eq("rd_c2_arvalid", 64'(axi.arvalid), 64'd0);
    @(negedge clk);
    check_eq("rd_c3_resp_valid", 64'(resp_valid), 64'd1);
    check_eq("rd_c3_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check_eq("rd_c4_req_ready", 64'(req_ready), 64'd1);
    check_eq("rd_c4_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rd_c4_rdata_hold", 64'(resp_rdata), 64'hDEAD_BEEF);

    // Write with W stalled until E0+4
    aw_wait = 0; w_wait = 3; b_wait = 0; bresp_k = 2'b00;
    do_req(1'b1, 2'd2, 32'h8000_0010, 32'h1234_5678, 8'h0F, 1'b1, {1'b0, 32'h0});
    @(negedge clk);
    check_eq("wr_c1_awvalid", 64'(axi.awvalid), 64'd1);
    check_eq("wr_c1_wvalid", 64'(axi.wvalid), 64'd1);
    check_eq("wr_c1_awaddr", 64'(axi.awaddr), 64'h8000_0010);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("wr_c%0d_awvalid", c), 64'(axi.awvalid), 64'd0);
      check_eq($sformatf("wr_c%0d_wvalid", c), 64'(axi.wvalid), 64'd1);
      check_eq($sformatf("wr_c%0d_wdata", c), 64'(axi.wdata), 64'h1234_5678);
      check_eq($sformatf("wr_c%0d_wstrb", c), 64'(axi.wstrb), 64'h0F);
      check_eq($sformatf("wr_c%0d_bready", c), 64'(axi.bready), 64'd0);
    end
    @(negedge clk);
    check_eq("wr_c5_wvalid", 64'(axi.wvalid), 64'd0);
    check_eq("wr_c5_bready", 64'(axi.bready), 64'd1);
    check_eq("wr_c5_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    check_eq("wr_c6_resp_valid", 64'(resp_valid), 64'd1);
    check_eq("wr_c6_bready", 64'(axi.bready), 64'd0);
    drain("wr_drain");
    w_wait = 0;

    // Read with AR stalled 5 cycles and SLVERR
    ar_wait = 5; rdata_k = 32'h0BAD_F00D; rresp_k = 2'b10;
    do_req(1'b0, 2'd2, 32'h8000_0044, '0, '0, 1'b1, {1'b1, 32'h0BAD_F00D});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("ar_stall_c%0d_arvalid", c), 64'(axi.arvalid), 64'd1);
      check_eq($sformatf("ar_stall_c%0d_araddr", c), 64'(axi.araddr), 64'h8000_0044);
    end
    drain("ar_stall_drain");
    ar_wait = 0; rresp_k = 2'b00;

    // Write with B delayed 7 cycles, DECERR; upper strobe bits pass through
    b_wait = 7; bresp_k = 2'b11;
    do_req(1'b1, 2'd2, 32'h8000_0020, 32'hCAFE_0001, 8'hA5, 1'b1, {1'b1, 32'h0});
    @(negedge clk);
    check_eq("bdly_c1_wstrb", 64'(axi.wstrb), 64'hA5);
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      check_eq($sformatf("bdly_c%0d_bready", c), 64'(axi.bready), 64'd1);
      check_eq($sformatf("bdly_c%0d_resp_valid", c), 64'(resp_valid), 64'd0);
    end
    @(negedge clk);
    check_eq("bdly_c10_resp_valid", 64'(resp_valid), 64'd1);
    @(negedge clk);
    check_eq("bdly_c11_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("bdly_c11_rdata_zero", 64'(resp_rdata), 64'd0);
    drain("bdly_drain");
    b_wait = 0; bresp_k = 2'b00;

    // Reset while waiting in RD_DATA: aborted read must not respond
    r_wait = 10;
    do_req(1'b0, 2'd2, 32'h8000_0080, '0, '0, 1'b0, '0);
    repeat (3) @(negedge clk);
    check_eq("abort_rready_before", 64'(axi.rready), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_rready", 64'(axi.rready), 64'd0);
    check_eq("abort_arvalid", 64'(axi.arvalid), 64'd0);
    check_eq("abort_req_ready", 64'(req_ready), 64'd0);
    check_eq("abort_resp_valid", 64'(resp_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready_after", 64'(req_ready), 64'd1);
    repeat (12) @(negedge clk);
    r_wait = 0;

`ifdef LSU_AXI_MISALIGN_CHECK_EN
    // Misaligned word read is answered locally
    do_req(1'b0, 2'd2, 32'h8000_0002, '0, '0, 1'b1, {1'b1, 32'h0});
    @(negedge clk);
    check_eq("mis_c1_arvalid", 64'(axi.arvalid), 64'd0);
    check_eq("mis_c1_resp_valid", 64'(resp_valid), 64'd1);
    @(negedge clk);
    check_eq("mis_c2_req_ready", 64'(req_ready), 64'd1);
    check_eq("mis_c2_arvalid", 64'(axi.arvalid), 64'd0);
    // Aligned half write at the same address proceeds
    do_req(1'b1, 2'd1, 32'h8000_0002, 32'h0000_BEEF, 8'h0C, 1'b1, {1'b0, 32'h0});
    @(negedge clk);
    check_eq("half_c1_awvalid", 64'(axi.awvalid), 64'd1);
    check_eq("half_c1_awaddr", 64'(axi.awaddr), 64'h8000_0002);
    drain("half_drain");
`else
    // Without the check, size is ignored and the address goes out unmodified
    rdata_k = 32'h5555_AAAA;
    do_req(1'b0, 2'd2, 32'h8000_0002, '0, '0, 1'b1, {1'b0, 32'h5555_AAAA});
    @(negedge clk);
    check_eq("nochk_c1_arvalid", 64'(axi.arvalid), 64'd1);
    check_eq("nochk_c1_araddr", 64'(axi.araddr), 64'h8000_0002);
    drain("nochk_drain");
`endif

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- AXI4-Lite initiator that turns a single-outstanding CPU load/store request into AXI-Lite channel transactions.
- It is the requesting end that drives the SRAM/peripheral responder already on the bus.
- Sits between the LSU/IFU request port and the memory bus.
- One transaction in flight at a time. Completion is returned as a one-cycle response pulse carrying data and error status.

Parameters:
- ADDR_WIDTH, 32, width of req_addr, araddr and awaddr.
- DATA_WIDTH, 32, width of req_wdata, wdata, rdata and resp_rdata.
- STRB_WIDTH, 8, width of req_wmask and wstrb. Bits above DATA_WIDTH/8 are passed through unchanged.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block idle and able to accept a request.
- req_wen  input  1  1 = write, 0 = read.
- req_size  input  2  0 = byte, 1 = half, 2 = word; used only by the optional feature.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data.
- req_wmask  input  STRB_WIDTH  byte strobes.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_WIDTH  load data; 0 for writes.
- resp_err  output  1  1 = bus or alignment error.
- araddr  output  ADDR_WIDTH  AR address.
- arvalid  output  1  AR valid.
- arready  input  1  AR ready.
- rdata  input  DATA_WIDTH  R data.
- rresp  input  2  R response.
- rvalid  input  1  R valid.
- rready  output  1  R ready.
- awaddr  output  ADDR_WIDTH  AW address.
- awvalid  output  1  AW valid.
- awready  input  1  AW ready.
- wdata  output  DATA_WIDTH  W data.
- wstrb  output  STRB_WIDTH  W strobes.
- wvalid  output  1  W valid.
- wready  input  1  W ready.
- bresp  input  2  B response.
- bvalid  input  1  B valid.
- bready  output  1  B ready.

Behaviour:
- Single clock `clk`; `rst` is asynchronous, active-high. All outputs are registered.
- Reset values (applied immediately on rst assertion): every output = 0, including req_ready; state = IDLE.
- First posedge after rst deasserts: req_ready becomes 1.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE:
  - On req_valid && req_ready, latch addr/wdata/wmask/wen and clear req_ready on the same edge.
  - req_wen=0 -> RD_ADDR, with arvalid=1 and araddr=latched addr.
  - req_wen=1 -> WR_REQ, with awvalid=wvalid=1 and awaddr/wdata/wstrb loaded.
- RD_ADDR:
  - arvalid and araddr held stable until an edge samples arready=1.
  - On that edge: arvalid -> 0, rready -> 1, go to RD_DATA.
- RD_DATA:
  - On an edge with rvalid && rready: capture rdata into resp_rdata; resp_err = (rresp != 2'b00); rready -> 0; resp_valid -> 1; go to RESP.
- WR_REQ:
  - AW and W complete independently. awvalid clears on the edge sampling awready=1; wvalid clears on the edge sampling wready=1.
  - Two done flags record completion. Simultaneous acceptance on one edge is legal.
  - Once both are done (checked on the accepting edge): bready -> 1, go to WR_RESP.
  - No valid is deasserted before its handshake.
- WR_RESP:
  - On an edge with bvalid && bready: resp_err = (bresp != 2'b00); resp_rdata = 0; bready -> 0; resp_valid -> 1; go to RESP.
- RESP:
  - resp_valid is high for exactly one cycle. The consumer cannot stall it.
  - Next edge: resp_valid -> 0, req_ready -> 1, go to IDLE.
  - resp_rdata and resp_err hold their values until the next completion.
- Minimum latency with a zero-wait responder (accept edge = E0):
  - Read: arvalid in cycle 1, rready in cycle 2, resp_valid in cycle 3.
  - Write: aw/wvalid in cycle 1, bready in cycle 2, resp_valid in cycle 3.
  - Back-to-back requests: a new request is accepted no sooner than 1 cycle after resp_valid.
- Arbitrary responder wait states are tolerated on every channel. There is no timeout.
- Reset mid-transaction: the block returns to IDLE immediately and all valid/ready outputs drop asynchronously. The aborted transaction produces no response.
- Unknown state encodings -> IDLE.

Optional Feature:
- Macro: LSU_AXI_MISALIGN_CHECK_EN.
- Defined: in IDLE, an accepted request is misaligned if (req_size==1 && addr[0]) or (req_size==2 && addr[1:0]!=0) or req_size==3.
  - A misaligned request issues no AR/AW/W and goes straight to RESP.
  - resp_valid in cycle 1, with resp_err=1 and resp_rdata=0.
- Undefined: req_size is ignored; every request goes to the bus with its address unmodified.

Test Plan:
- Read, zero-wait responder returning rdata=0xDEADBEEF, rresp=0 at addr 0x80000004 -> araddr=0x80000004; resp_valid exactly at E0+3 with resp_rdata=0xDEADBEEF, resp_err=0; req_ready=1 at E0+4.
- Write to addr 0x80000010, wdata=0x12345678, wmask=0x0F; awready at E0+1, wready stalled until E0+4 -> awvalid drops after E0+1; wvalid held until E0+4 with wdata/wstrb stable; bready from E0+5; resp_valid follows bvalid, resp_err=0.
- Read with arready low for 5 cycles and rresp=2'b10 -> arvalid/araddr stable for all 5 cycles; resp_err=1.
- Write with bvalid delayed 7 cycles after bready rises -> no resp_valid until after the bvalid handshake; then exactly one resp_valid pulse.
- rst asserted while in RD_DATA -> rready, arvalid and req_ready = 0 without a clock edge; no resp_valid; req_ready=1 one edge after rst deasserts.
- (LSU_AXI_MISALIGN_CHECK_EN) word read at 0x80000002 -> no arvalid; resp_valid at E0+1 with resp_err=1; half write at 0x80000002 proceeds normally.
